rect_renderer: RTL and testbench

Drawing engine on the GPU side of the double-buffered frame path, on `gpu_clk_150`. On a start request from the frame director it clears the back buffer to a background colour and then rasterises a stream of filled rectangles from a command port. It drives the director's `gpu_x`/`gpu_y`/`gpu_data`/`gpu_we` write port, one pixel per clock, and signals frame completion on `gpu_done`.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/rect_renderer_if.sv | 35 +++
 rtl/bit_synchronizer.sv | 31 +++
 rtl/rect_renderer.sv | 170 +++++++++++++++++
 tb/tb_rect_renderer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and default frame geometry for the GPU drawing path
//
// Purpose: renderer state encoding, rectangle command record and default
// display dimensions shared by the rectangle renderer and its neighbours.
package gpu_pkg;

  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;
  localparam int STEP_DEF    = 2;

  typedef enum logic [1:0] {
    DONE     = 2'd0,
    CLEAR    = 2'd1,
    WAIT_CMD = 2'd2,
    DRAW     = 2'd3
  } rend_state_t;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [3:0] color;
    logic       last;
  } rect_cmd_t;

endpackage

// File: rtl/rect_renderer_if.sv
// rtl/rect_renderer_if.sv - command port and pixel write port of the rectangle renderer
//
// Purpose: bundles the rectangle command handshake and the frame-buffer write port.
// Modports:
//   master - the renderer: consumes commands, drives cmd_ready and the write port
//   slave  - the command source / frame director side
interface rect_renderer_if;
  import gpu_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_x0;
  logic [9:0] cmd_y0;
  logic [9:0] cmd_x1;
  logic [9:0] cmd_y1;
  logic [3:0] cmd_color;
  logic       cmd_last;

  logic [9:0] gpu_x;
  logic [9:0] gpu_y;
  logic [3:0] gpu_data;
  logic       gpu_we;
  logic       gpu_done;

  modport master (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_last,
    output cmd_ready, gpu_x, gpu_y, gpu_data, gpu_we, gpu_done
  );

  modport slave (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_last,
    input  cmd_ready, gpu_x, gpu_y, gpu_data, gpu_we, gpu_done
  );

endinterface

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - two-flop synchroniser for a single level signal
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset, clears both stages
//   i_d   in  asynchronous level
//   o_q   out synchronised level, two clocks of latency
module bit_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rect_renderer.sv
// rtl/rect_renderer.sv - back-buffer clear and filled-rectangle rasteriser
//
// Purpose: on a start event clears the back buffer to bg_color, then fills
// rectangles from the command port, one buffer cell per clock.
// Ports:
//   clk       in  GPU clock
//   reset     in  asynchronous active-low reset
//   gpu_start in  start request from the frame director (other clock domain)
//   bg_color  in  clear colour, sampled with the start event
//   bus       master side of rect_renderer_if (commands in, pixel writes out)
module rect_renderer
  import gpu_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF,
  parameter int STEP    = STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gpu_start,
  input  logic [3:0]       bg_color,
  rect_renderer_if.master  bus
);

  // Coordinates are carried in 11 bits so x+STEP never wraps near 1023.
  localparam logic [10:0] W_LAST = 11'(FRAME_W - STEP);
  localparam logic [10:0] H_LAST = 11'(FRAME_H - STEP);
  localparam logic [10:0] W_MAX  = 11'(FRAME_W - 1);
  localparam logic [10:0] H_MAX  = 11'(FRAME_H - 1);
  localparam logic [10:0] W_LIM  = 11'(FRAME_W);
  localparam logic [10:0] H_LIM  = 11'(FRAME_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  CELL_MASK = ~10'(STEP - 1);

  rend_state_t r_state;
  logic [10:0] r_x, r_y;
  logic [10:0] r_xs, r_xe, r_ye;
  logic [3:0]  r_data;
  logic        r_we, r_done, r_ready, r_last;
  logic        r_start_prev;

  logic        w_start_sync;
  logic        w_start_evt;
  rect_cmd_t   w_cmd;
  logic [10:0] w_xs, w_ys, w_x1, w_y1, w_xe, w_ye;
  logic [10:0] w_x_next, w_y_next;
  logic        w_empty;

  bit_synchronizer u_start_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (gpu_start),
    .o_q   (w_start_sync)
  );

  // Only the rising edge starts a frame; a held level is ignored.
  assign w_start_evt = w_start_sync & ~r_start_prev;

  assign w_cmd = '{x0: bus.cmd_x0, y0: bus.cmd_y0, x1: bus.cmd_x1, y1: bus.cmd_y1,
                   color: bus.cmd_color, last: bus.cmd_last};

  // Start corner snaps down to a cell boundary; end corner clips to the frame.
  assign w_xs = {1'b0, w_cmd.x0 & CELL_MASK};
  assign w_ys = {1'b0, w_cmd.y0 & CELL_MASK};
  assign w_x1 = {1'b0, w_cmd.x1};
  assign w_y1 = {1'b0, w_cmd.y1};
  assign w_xe = (w_x1 > W_MAX) ? W_MAX : w_x1;
  assign w_ye = (w_y1 > H_MAX) ? H_MAX : w_y1;
  assign w_empty = (w_xs > w_xe) || (w_ys > w_ye) || (w_xs >= W_LIM) || (w_ys >= H_LIM);

  assign w_x_next = r_x + STEP11;
  assign w_y_next = r_y + STEP11;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= DONE;
      r_x          <= '0;
      r_y          <= '0;
      r_xs         <= '0;
      r_xe         <= '0;
      r_ye         <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_done       <= 1'b1;
      r_ready      <= 1'b0;
      r_last       <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_start_prev <= w_start_sync;
      case (r_state)
        DONE: begin
          // The first clear write is issued together with the state change.
          if (w_start_evt) begin
            r_state <= CLEAR;
            r_data  <= bg_color;
            r_x     <= '0;
            r_y     <= '0;
            r_we    <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        CLEAR: begin
          if (r_x == W_LAST) begin
            r_x <= '0;
            if (r_y == H_LAST) begin
              r_state <= WAIT_CMD;
              r_y     <= '0;
              r_we    <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_y <= w_y_next;
            end
          end else begin
            r_x <= w_x_next;
          end
        end
        WAIT_CMD: begin
          if (bus.cmd_valid && r_ready) begin
            r_last <= w_cmd.last;
            if (w_empty) begin
              if (w_cmd.last) begin
                r_state <= DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_state <= DRAW;
              r_ready <= 1'b0;
              r_we    <= 1'b1;
              r_x     <= w_xs;
              r_y     <= w_ys;
              r_data  <= w_cmd.color;
              r_xs    <= w_xs;
              r_xe    <= w_xe;
              r_ye    <= w_ye;
            end
          end
        end
        DRAW: begin
          if (w_x_next > r_xe) begin
            if (w_y_next > r_ye) begin
              r_we <= 1'b0;
              if (r_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= WAIT_CMD;
                r_ready <= 1'b1;
              end
            end else begin
              r_x <= r_xs;
              r_y <= w_y_next;
            end
          end else begin
            r_x <= w_x_next;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.gpu_x     = r_x[9:0];
  assign bus.gpu_y     = r_y[9:0];
  assign bus.gpu_data  = r_data;
  assign bus.gpu_we    = r_we;
  assign bus.gpu_done  = r_done;

endmodule

// File: tb/tb_rect_renderer.sv
// tb/tb_rect_renderer.sv - self-checking bench for rect_renderer
module tb_rect_renderer;
  import gpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, start_a, start_b;
  logic [3:0] bg;
  logic       cmd_valid, cmd_last;
  logic [9:0] cx0, cy0, cx1, cy1;
  logic [3:0] ccol;

  rect_renderer_if ifa ();
  rect_renderer_if ifb ();

  assign ifa.cmd_valid = cmd_valid;
  assign ifa.cmd_x0    = cx0;
  assign ifa.cmd_y0    = cy0;
  assign ifa.cmd_x1    = cx1;
  assign ifa.cmd_y1    = cy1;
  assign ifa.cmd_color = ccol;
  assign ifa.cmd_last  = cmd_last;
  assign ifb.cmd_valid = cmd_valid;
  assign ifb.cmd_x0    = cx0;
  assign ifb.cmd_y0    = cy0;
  assign ifb.cmd_x1    = cx1;
  assign ifb.cmd_y1    = cy1;
  assign ifb.cmd_color = ccol;
  assign ifb.cmd_last  = cmd_last;

  rect_renderer dut_a (
    .clk       (clk),
    .reset     (rst_a),
    .gpu_start (start_a),
    .bg_color  (bg),
    .bus       (ifa)
  );

  rect_renderer #(.FRAME_W(32), .FRAME_H(16), .STEP(2)) dut_b (
    .clk       (clk),
    .reset     (rst_b),
    .gpu_start (start_b),
    .bg_color  (bg),
    .bus       (ifb)
  );

  logic       sel;
  logic       mon_en;
  logic       mon_we, mon_done, mon_ready;
  logic [9:0] mon_x, mon_y;
  logic [3:0] mon_d;

  always_comb begin
    mon_we    = sel ? ifb.gpu_we    : ifa.gpu_we;
    mon_done  = sel ? ifb.gpu_done  : ifa.gpu_done;
    mon_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
    mon_x     = sel ? ifb.gpu_x     : ifa.gpu_x;
    mon_y     = sel ? ifb.gpu_y     : ifa.gpu_y;
    mon_d     = sel ? ifb.gpu_data  : ifa.gpu_data;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int fw, fh;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write must match the oldest expected {x, y, data}.
  always @(negedge clk) begin
    if (mon_en && mon_we) begin
      logic [23:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
      check("pixel_write", {mon_x, mon_y, mon_d}, e);
    end
  end

  task automatic push_rect(input int xs, input int ys, input int xe, input int ye, input logic [3:0] c);
    for (int y = ys; y <= ye; y += 2)
      for (int x = xs; x <= xe; x += 2)
        exp_q.push_back({10'(x), 10'(y), c});
  endtask

  task automatic count_writes(output int n);
    n = 0;
    while (mon_we && n < 80000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_clear(input logic [3:0] c, input bit on_b, input int exp_n);
    int n;
    push_rect(0, 0, fw - 1, fh - 1, c);
    bg = c;
    @(posedge clk); #1;
    if (on_b) start_b = 1'b1; else start_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("start_done_still_high", mon_done, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("start_done_fell", mon_done, 1'b0);
    check("start_first_write", mon_we, 1'b1);
    count_writes(n);
    check("clear_count", n, exp_n);
    check("clear_ready_after", mon_ready, 1'b1);
    check("clear_done_low", mon_done, 1'b0);
    check("clear_queue_empty", exp_q.size(), 0);
  endtask

  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                          input logic [3:0] c, input bit lst);
    int t;
    cx0 = 10'(x0); cy0 = 10'(y0); cx1 = 10'(x1); cy1 = 10'(y1);
    ccol = c; cmd_last = lst; cmd_valid = 1'b1;
    t = 0;
    while (!mon_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_handshake_ready", mon_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input logic [3:0] c, input bit lst, input int exp_n);
    int xs, ys, xe, ye, n;
    xs = x0 & ~1;
    ys = y0 & ~1;
    xe = (x1 > fw - 1) ? fw - 1 : x1;
    ye = (y1 > fh - 1) ? fh - 1 : y1;
    if (xs < fw && ys < fh) push_rect(xs, ys, xe, ye, c);
    send_cmd(x0, y0, x1, y1, c, lst);
    count_writes(n);
    check("cmd_write_count", n, exp_n);
    check("cmd_done_after", mon_done, lst);
    check("cmd_ready_after", mon_ready, !lst);
    check("cmd_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    sel = 1'b0; mon_en = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    bg = '0; cmd_valid = 1'b0; cmd_last = 1'b0;
    cx0 = '0; cy0 = '0; cx1 = '0; cy1 = '0; ccol = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1; rst_b = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_done", mon_done, 1'b1);
    check("reset_we", mon_we, 1'b0);
    check("reset_ready", mon_ready, 1'b0);
    check("reset_xy_data", {mon_x, mon_y, mon_d}, 24'h0);

    // Full-size frame; gpu_start stays high throughout.
    fw = 640; fh = 480;
    run_clear(4'hA, 1'b0, 76800);
    run_cmd(11, 4, 13, 7, 4'h5, 1'b0, 4);
    run_cmd(20, 0, 10, 5, 4'h7, 1'b0, 0);
    run_cmd(630, 476, 700, 900, 4'h3, 1'b1, 10);
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!mon_done || mon_we) n++;
    end
    check("held_start_no_retrigger", n, 0);
    start_a = 1'b0;

    // Small frame: empty last command, then reset during DRAW.
    sel = 1'b1; fw = 32; fh = 16;
    run_clear(4'h6, 1'b1, 128);
    run_cmd(20, 0, 10, 5, 4'h9, 1'b1, 0);
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    run_clear(4'h1, 1'b1, 128);
    mon_en = 1'b0;
    send_cmd(0, 0, 31, 15, 4'h2, 1'b1);
    repeat (4) @(negedge clk);
    check("draw_in_progress", mon_we, 1'b1);
    rst_b = 1'b0;
    start_b = 1'b0;
    #1;
    check("reset_mid_draw_we", mon_we, 1'b0);
    check("reset_mid_draw_done", mon_done, 1'b1);
    check("reset_mid_draw_ready", mon_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    run_clear(4'hC, 1'b1, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
